fetch_unit: RTL and testbench

Instruction fetch stage that consumes the program-counter redirects produced by `pc_control` and turns them into instruction-memory requests. It delivers `{inst, inst_pc}` pairs to decode through a small in-order buffer, honouring the same `stall` back-pressure that freezes the PC. It sits between `pc_control`/hazard logic on one side and the instruction memory port on the other. It keeps at most one memory request outstanding and discards responses made stale by a redirect.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one outstanding request and in-order instruction buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirectAddress,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_buf_pc   [DEPTH];
  logic [31:0]   r_buf_inst [DEPTH];

  logic          w_req;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_inst_valid;
  logic [31:0]   w_redir_pc;

  // Low two bits of the redirect target are forced to zero (word aligned fetch).
  assign w_redir_pc   = redirectAddress & ~32'h0000_0003;
  assign w_req        = !reset && (r_state == S_RUN) && (r_count < CNT_FULL);
  assign w_accept     = w_req && imem_ready;
  // A redirect flushes the buffer, so it also suppresses any push or pop in its cycle.
  assign w_push       = !redirect && (r_state == S_WAIT) && imem_valid;
  assign w_inst_valid = !reset && (r_count != '0) && !redirect;
  assign w_pop        = w_inst_valid && !stall;

  assign imem_req   = w_req;
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = w_inst_valid;
  assign inst       = r_buf_inst[r_rd_ptr];
  assign inst_pc    = r_buf_pc[r_rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: track the single outstanding request; a redirect marks it stale (DROP).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_accept) w_state_nxt = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid)    w_state_nxt = S_RUN;
        else if (redirect) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (imem_valid) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Fetch and request PC: redirect wins, otherwise advance on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
    end else begin
      if (w_accept) r_req_pc <= r_fetch_pc;
      if (redirect) begin
        r_fetch_pc <= w_redir_pc;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  // Buffer pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_req_pc;
      r_buf_inst[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirectAddress;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int tests  = 0;
  int failed = 0;

  int          lat;
  int          pend;
  logic [31:0] pend_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirectAddress(redirectAddress),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_data(imem_data), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; memory model answers an accepted request after lat cycles with addr^K.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    imem_data  = 32'h0;
    if (acc) begin
      pend      = lat;
      pend_addr = a;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_valid = 1'b1;
        imem_data  = pend_addr ^ K;
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirectAddress = 32'h0; imem_ready = 1'b1;
    imem_valid = 1'b0; imem_data = 32'h0; stall = 1'b0; lat = 1; pend = 0; pend_addr = 32'h0;
    tick(); tick(); #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);

    // Streaming
    reset = 1'b0; #1;
    chk("s0_req", {31'h0, imem_req}, 32'h1);
    chk("s0_addr", imem_addr, 32'h0);
    tick(); #1;
    chk("s1_req", {31'h0, imem_req}, 32'h0);
    chk("s1_valid", {31'h0, inst_valid}, 32'h0);
    tick(); #1;
    chk("s2_valid", {31'h0, inst_valid}, 32'h1);
    chk("s2_pc", inst_pc, 32'h0);
    chk("s2_inst", inst, 32'h1357_9BDF);
    chk("s2_addr", imem_addr, 32'h4);
    tick(); #1;
    chk("s3_valid", {31'h0, inst_valid}, 32'h0);
    tick(); #1;
    chk("s4_pc", inst_pc, 32'h4);
    chk("s4_inst", inst, 32'h1357_9BDB);
    tick(); tick(); #1;
    chk("s6_pc", inst_pc, 32'h8);
    chk("s6_inst", inst, 32'h1357_9BD7);
    tick(); tick(); #1;
    chk("s8_valid", {31'h0, inst_valid}, 32'h1);
    chk("s8_pc", inst_pc, 32'hC);
    chk("s8_inst", inst, 32'h1357_9BD3);

    // Back-pressure from a fresh reset
    reset = 1'b1; stall = 1'b1; #1;
    chk("r_valid", {31'h0, inst_valid}, 32'h0);
    tick(); tick();
    reset = 1'b0; #1;
    chk("b0_addr", imem_addr, 32'h0);
    tick(); tick(); #1;
    chk("b2_pc", inst_pc, 32'h0);
    chk("b2_addr", imem_addr, 32'h4);
    tick(); tick(); #1;
    chk("b4_req", {31'h0, imem_req}, 32'h0);
    chk("b4_pc", inst_pc, 32'h0);
    tick(); #1;
    chk("b5_req", {31'h0, imem_req}, 32'h0);
    chk("b5_pc", inst_pc, 32'h0);
    stall = 1'b0; #1;
    tick(); #1;
    chk("b6_pc", inst_pc, 32'h4);
    chk("b6_inst", inst, 32'h1357_9BDB);
    chk("b6_req", {31'h0, imem_req}, 32'h1);
    chk("b6_addr", imem_addr, 32'h8);
    tick(); #1;
    chk("b7_valid", {31'h0, inst_valid}, 32'h0);
    lat = 2;
    tick(); #1;
    chk("b8_pc", inst_pc, 32'h8);
    chk("b8_addr", imem_addr, 32'hC);

    // Redirect while WAIT, stale response two cycles later
    tick();
    redirect = 1'b1; redirectAddress = 32'h0000_0040; #1;
    chk("w_req", {31'h0, imem_req}, 32'h0);
    chk("w_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    redirect = 1'b0; lat = 1; #1;
    chk("w_stale_resp", {31'h0, imem_valid}, 32'h1);
    chk("w_drop_req", {31'h0, imem_req}, 32'h0);
    tick(); #1;
    chk("w_new_req", {31'h0, imem_req}, 32'h1);
    chk("w_new_addr", imem_addr, 32'h40);
    chk("w_no_c", {31'h0, inst_valid}, 32'h0);
    tick(); tick(); #1;
    chk("w_pc", inst_pc, 32'h40);
    chk("w_inst", inst, 32'h1357_9B9F);

    // Redirect in the same cycle as the response
    tick();
    redirect = 1'b1; redirectAddress = 32'h0000_0080; #1;
    chk("c_resp", {31'h0, imem_valid}, 32'h1);
    chk("c_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    redirect = 1'b0; imem_ready = 1'b0; #1;
    chk("c_req", {31'h0, imem_req}, 32'h1);
    chk("c_addr", imem_addr, 32'h80);
    chk("c_nvalid", {31'h0, inst_valid}, 32'h0);

    // Ready low for 3 cycles, then redirect to a misaligned address near the top
    tick(); #1;
    chk("rl1_req", {31'h0, imem_req}, 32'h1);
    chk("rl1_addr", imem_addr, 32'h80);
    tick(); #1;
    chk("rl2_req", {31'h0, imem_req}, 32'h1);
    chk("rl2_addr", imem_addr, 32'h80);
    tick();
    redirect = 1'b1; redirectAddress = 32'hFFFF_FFFE; #1;
    tick();
    redirect = 1'b0; imem_ready = 1'b1; #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick(); #1;
    chk("wr_pc0", inst_pc, 32'hFFFF_FFFC);
    chk("wr_inst0", inst, 32'hECA8_6423);
    chk("wr_next_addr", imem_addr, 32'h0);
    tick(); tick(); #1;
    chk("wr_pc1", inst_pc, 32'h0);
    chk("wr_inst1", inst, 32'h1357_9BDF);
    lat = 3;

    // Reset while WAIT; late response lands in RUN and must be ignored
    tick();
    reset = 1'b1; #1;
    chk("rm_req", {31'h0, imem_req}, 32'h0);
    chk("rm_valid", {31'h0, inst_valid}, 32'h0);
    tick(); #1;
    chk("rm_valid2", {31'h0, inst_valid}, 32'h0);
    tick();
    reset = 1'b0; lat = 1; #1;
    chk("rm_stray", {31'h0, imem_valid}, 32'h1);
    chk("rm_req2", {31'h0, imem_req}, 32'h1);
    chk("rm_addr", imem_addr, 32'h0);
    tick(); #1;
    chk("rm_nvalid", {31'h0, inst_valid}, 32'h0);
    tick(); #1;
    chk("rm_fvalid", {31'h0, inst_valid}, 32'h1);
    chk("rm_pc", inst_pc, 32'h0);
    chk("rm_inst", inst, 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
